// File: rtl/ps2_mouse_tracker_if.sv
// Byte-receiver input and cursor/status output bundle for the PS/2 mouse tracker.
// The master side drives the received bytes; the slave side is the tracker itself.
interface ps2_mouse_tracker_if #(
    parameter int POS_W   = 10,
    parameter int WHEEL_W = 8
);
    logic                      Enable;
    logic [7:0]                RxData;
    logic                      RxValid;
    logic                      RxError;
    logic [POS_W-1:0]          PosX;
    logic [POS_W-1:0]          PosY;
    logic signed [WHEEL_W-1:0] Wheel;
    logic [2:0]                Buttons;
    logic                      PacketStrobe;
    logic                      SyncError;

    modport master (
        output Enable, RxData, RxValid, RxError,
        input  PosX, PosY, Wheel, Buttons, PacketStrobe, SyncError
    );

    modport slave (
        input  Enable, RxData, RxValid, RxError,
        output PosX, PosY, Wheel, Buttons, PacketStrobe, SyncError
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles PS/2 mouse packets into a clamped absolute cursor position, a saturating wheel
// count and button state; malformed, errored or stalled packets are dropped with SyncError.
module ps2_mouse_tracker #(
    parameter int POS_W       = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int WHEEL_MODE  = 0,
    parameter int WHEEL_W     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic           Clk,
    input logic           Reset,
    ps2_mouse_tracker_if.slave bus
);

    localparam logic [1:0] BYTE0 = 2'd0;
    localparam logic [1:0] BYTE1 = 2'd1;
    localparam logic [1:0] BYTE2 = 2'd2;
    localparam logic [1:0] BYTE3 = 2'd3;
    localparam logic [1:0] LAST_STATE = (WHEEL_MODE != 0) ? BYTE3 : BYTE2;

    localparam int AW = POS_W + 2;
    localparam int ZW = ((WHEEL_W > 4) ? WHEEL_W : 4) + 2;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic signed [AW-1:0] X_MAX_S    = AW'(X_MAX);
    localparam logic signed [AW-1:0] Y_MAX_S    = AW'(Y_MAX);
    localparam logic signed [ZW-1:0] W_MAX      = ZW'((1 << (WHEEL_W - 1)) - 1);
    localparam logic signed [ZW-1:0] W_MIN      = ZW'(-(1 << (WHEEL_W - 1)));

    logic [1:0]                state;
    logic [TW-1:0]             timer;
    logic [2:0]                hdr_btn;
    logic                      hdr_sx;
    logic                      hdr_sy;
    logic                      hdr_ox;
    logic                      hdr_oy;
    logic [7:0]                b1_q;
    logic [7:0]                b2_q;
    logic [POS_W-1:0]          pos_x;
    logic [POS_W-1:0]          pos_y;
    logic signed [WHEEL_W-1:0] wheel;
    logic [2:0]                buttons;
    logic                      packet_strobe;
    logic                      sync_error;

    logic                      apply_now;
    logic [7:0]                dy_low;
    logic signed [8:0]         dx9;
    logic signed [8:0]         dy9;
    logic signed [AW-1:0]      dx;
    logic signed [AW-1:0]      dy;
    logic signed [AW-1:0]      x_sum;
    logic signed [AW-1:0]      y_sum;
    logic [POS_W-1:0]          x_next;
    logic [POS_W-1:0]          y_next;
    logic signed [ZW-1:0]      dz;
    logic signed [ZW-1:0]      z_sum;
    logic signed [WHEEL_W-1:0] wheel_next;

    // The final byte is still on RxData when the packet is applied, so take it straight from the bus.
    always_comb begin
        apply_now = bus.Enable && bus.RxValid && !bus.RxError && (state == LAST_STATE);
        dy_low    = (WHEEL_MODE != 0) ? b2_q : bus.RxData;
        dx9       = {hdr_sx, b1_q};
        dy9       = {hdr_sy, dy_low};

        dx = '0;
        dy = '0;
        if (!hdr_ox) dx = AW'(dx9);
        if (!hdr_oy) dy = AW'(dy9);

        x_sum = $signed({2'b00, pos_x}) + dx;
        y_sum = $signed({2'b00, pos_y}) - dy;

        if (x_sum < 0)             x_next = '0;
        else if (x_sum > X_MAX_S)  x_next = POS_W'(X_MAX);
        else                       x_next = x_sum[POS_W-1:0];

        if (y_sum < 0)             y_next = '0;
        else if (y_sum > Y_MAX_S)  y_next = POS_W'(Y_MAX);
        else                       y_next = y_sum[POS_W-1:0];

        dz    = ZW'($signed(bus.RxData[3:0]));
        z_sum = ZW'(wheel) + dz;
        if (z_sum > W_MAX)         wheel_next = WHEEL_W'(W_MAX);
        else if (z_sum < W_MIN)    wheel_next = WHEEL_W'(W_MIN);
        else                       wheel_next = z_sum[WHEEL_W-1:0];
    end

    // Priority: reset, then Enable low (silent drop), then RxError, then byte, then timeout.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= BYTE0;
            timer         <= '0;
            hdr_btn       <= '0;
            hdr_sx        <= 1'b0;
            hdr_sy        <= 1'b0;
            hdr_ox        <= 1'b0;
            hdr_oy        <= 1'b0;
            b1_q          <= '0;
            b2_q          <= '0;
            pos_x         <= POS_W'(X_MAX >> 1);
            pos_y         <= POS_W'(Y_MAX >> 1);
            wheel         <= '0;
            buttons       <= '0;
            packet_strobe <= 1'b0;
            sync_error    <= 1'b0;
        end else begin
            packet_strobe <= 1'b0;
            sync_error    <= 1'b0;

            if (!bus.Enable) begin
                state <= BYTE0;
                timer <= '0;
            end else if (bus.RxError) begin
                state      <= BYTE0;
                timer      <= '0;
                sync_error <= 1'b1;
            end else if (bus.RxValid) begin
                timer <= '0;
                case (state)
                    BYTE0: begin
                        if (bus.RxData[3]) begin
                            hdr_oy  <= bus.RxData[7];
                            hdr_ox  <= bus.RxData[6];
                            hdr_sy  <= bus.RxData[5];
                            hdr_sx  <= bus.RxData[4];
                            hdr_btn <= bus.RxData[2:0];
                            state   <= BYTE1;
                        end else begin
                            sync_error <= 1'b1;
                        end
                    end
                    BYTE1: begin
                        b1_q  <= bus.RxData;
                        state <= BYTE2;
                    end
                    BYTE2: begin
                        b2_q  <= bus.RxData;
                        state <= (WHEEL_MODE != 0) ? BYTE3 : BYTE0;
                    end
                    default: state <= BYTE0;
                endcase
            end else if (state != BYTE0) begin
                if (timer == TIMER_LAST) begin
                    state      <= BYTE0;
                    timer      <= '0;
                    sync_error <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end

            if (apply_now) begin
                pos_x         <= x_next;
                pos_y         <= y_next;
                buttons       <= hdr_btn;
                packet_strobe <= 1'b1;
                if (WHEEL_MODE != 0) wheel <= wheel_next;
            end
        end
    end

    assign bus.PosX         = pos_x;
    assign bus.PosY         = pos_y;
    assign bus.Wheel        = wheel;
    assign bus.Buttons      = buttons;
    assign bus.PacketStrobe = packet_strobe;
    assign bus.SyncError    = sync_error;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench: a 3-byte tracker with a short timeout and a 4-byte wheel tracker with a
// 4-bit wheel accumulator, driven from a vector table plus hand-written corner sequences.
module tb_ps2_mouse_tracker;

    localparam int TO = 40;
    localparam int NV = 18;

    logic Clk = 1'b0;
    logic Reset;

    always #10 Clk = ~Clk;

    ps2_mouse_tracker_if #(.POS_W(10), .WHEEL_W(8)) bus0 ();
    ps2_mouse_tracker_if #(.POS_W(10), .WHEEL_W(4)) bus1 ();

    ps2_mouse_tracker #(
        .POS_W(10), .X_MAX(639), .Y_MAX(479),
        .WHEEL_MODE(0), .WHEEL_W(8), .TIMEOUT_CYC(TO)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0.slave)
    );

    ps2_mouse_tracker #(
        .POS_W(10), .X_MAX(639), .Y_MAX(479),
        .WHEEL_MODE(1), .WHEEL_W(4), .TIMEOUT_CYC(1000)
    ) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(bus1.slave)
    );

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         expX;
        int         expY;
        int         expBtn;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One byte strobe; returns on the falling edge after the capturing rising edge.
    task automatic applyStimulus(input int unit, input logic [7:0] data, input logic err);
        @(negedge Clk);
        if (unit == 0) begin
            bus0.RxData = data; bus0.RxValid = 1'b1; bus0.RxError = err;
        end else begin
            bus1.RxData = data; bus1.RxValid = 1'b1; bus1.RxError = err;
        end
        @(negedge Clk);
        bus0.RxValid = 1'b0; bus0.RxError = 1'b0;
        bus1.RxValid = 1'b0; bus1.RxError = 1'b0;
    endtask

    task automatic sendPacket3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        applyStimulus(0, a, 1'b0);
        applyStimulus(0, b, 1'b0);
        applyStimulus(0, c, 1'b0);
    endtask

    task automatic sendPacket4(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        applyStimulus(1, a, 1'b0);
        applyStimulus(1, b, 1'b0);
        applyStimulus(1, c, 1'b0);
        applyStimulus(1, d, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int wExp;

        vecs[0]  = '{8'h08, 8'h05, 8'h03, 324, 236, 0};
        vecs[1]  = '{8'h09, 8'h00, 8'h00, 324, 236, 1};
        vecs[2]  = '{8'h1A, 8'hFB, 8'h00, 319, 236, 2};
        vecs[3]  = '{8'h28, 8'h00, 8'h0A, 319, 479, 0};
        vecs[4]  = '{8'h08, 8'h00, 8'hFF, 319, 224, 0};
        vecs[5]  = '{8'h08, 8'h00, 8'hFF, 319,   0, 0};
        vecs[6]  = '{8'h18, 8'h00, 8'h00,  63,   0, 0};
        vecs[7]  = '{8'h18, 8'h80, 8'h00,   0,   0, 0};
        vecs[8]  = '{8'h08, 8'hFF, 8'h00, 255,   0, 0};
        vecs[9]  = '{8'h08, 8'hFF, 8'h00, 510,   0, 0};
        vecs[10] = '{8'h08, 8'hFF, 8'h00, 639,   0, 0};
        vecs[11] = '{8'h48, 8'h7F, 8'h00, 639,   0, 0};
        vecs[12] = '{8'hA8, 8'h00, 8'h00, 639,   0, 0};
        vecs[13] = '{8'h1C, 8'hFD, 8'h00, 636,   0, 4};
        vecs[14] = '{8'h18, 8'hFB, 8'h00, 631,   0, 0};
        vecs[15] = '{8'h08, 8'h0A, 8'h00, 639,   0, 0};
        vecs[16] = '{8'h2F, 8'h00, 8'hF6, 639,  10, 7};
        vecs[17] = '{8'h38, 8'h9C, 8'h02, 539, 264, 0};

        Reset = 1'b1;
        bus0.Enable = 1'b1; bus0.RxData = '0; bus0.RxValid = 1'b0; bus0.RxError = 1'b0;
        bus1.Enable = 1'b1; bus1.RxData = '0; bus1.RxValid = 1'b0; bus1.RxError = 1'b0;
        repeat (3) @(negedge Clk);

        checkOutput("reset_posx",   bus0.PosX, 319);
        checkOutput("reset_posy",   bus0.PosY, 239);
        checkOutput("reset_wheel",  bus1.Wheel, 0);
        checkOutput("reset_btn",    bus0.Buttons, 0);
        checkOutput("reset_strobe", bus0.PacketStrobe, 0);
        checkOutput("reset_sync",   bus0.SyncError, 0);
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(0, vecs[i].b0, 1'b0);
            applyStimulus(0, vecs[i].b1, 1'b0);
            checkOutput($sformatf("v%0d_strobe_early", i), bus0.PacketStrobe, 0);
            applyStimulus(0, vecs[i].b2, 1'b0);
            checkOutput($sformatf("v%0d_strobe", i), bus0.PacketStrobe, 1);
            checkOutput($sformatf("v%0d_sync", i),   bus0.SyncError, 0);
            checkOutput($sformatf("v%0d_posx", i),   bus0.PosX, vecs[i].expX);
            checkOutput($sformatf("v%0d_posy", i),   bus0.PosY, vecs[i].expY);
            checkOutput($sformatf("v%0d_btn", i),    bus0.Buttons, vecs[i].expBtn);
            @(negedge Clk);
            checkOutput($sformatf("v%0d_strobe_end", i), bus0.PacketStrobe, 0);
        end

        // Bad sync byte is rejected without advancing.
        applyStimulus(0, 8'h00, 1'b0);
        checkOutput("badsync_sync",   bus0.SyncError, 1);
        checkOutput("badsync_strobe", bus0.PacketStrobe, 0);
        @(negedge Clk);
        checkOutput("badsync_sync_end", bus0.SyncError, 0);
        sendPacket3(8'h09, 8'h00, 8'h00);
        checkOutput("badsync_pkt_strobe", bus0.PacketStrobe, 1);
        checkOutput("badsync_pkt_btn",    bus0.Buttons, 1);
        checkOutput("badsync_pkt_posx",   bus0.PosX, 539);

        // Stall mid-packet until the timeout resynchronises the FSM.
        applyStimulus(0, 8'h08, 1'b0);
        applyStimulus(0, 8'h05, 1'b0);
        checkOutput("timeout_sync_early", bus0.SyncError, 0);
        seen = -1;
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge Clk);
            if (bus0.SyncError) begin
                seen = k;
                break;
            end
        end
        checkOutput("timeout_cycle", seen, TO);
        sendPacket3(8'h08, 8'h01, 8'h00);
        checkOutput("timeout_pkt_strobe", bus0.PacketStrobe, 1);
        checkOutput("timeout_pkt_posx",   bus0.PosX, 540);
        checkOutput("timeout_pkt_btn",    bus0.Buttons, 0);

        // RxError together with RxValid on the second byte.
        applyStimulus(0, 8'h08, 1'b0);
        applyStimulus(0, 8'h05, 1'b1);
        checkOutput("rxerr_sync",   bus0.SyncError, 1);
        checkOutput("rxerr_strobe", bus0.PacketStrobe, 0);
        sendPacket3(8'h08, 8'h01, 8'h00);
        checkOutput("rxerr_pkt_posx", bus0.PosX, 541);

        // RxError alone while idle.
        @(negedge Clk);
        bus0.RxError = 1'b1;
        @(negedge Clk);
        bus0.RxError = 1'b0;
        checkOutput("rxerr_alone_sync", bus0.SyncError, 1);

        // Back-to-back packets: a new header on the cycle PacketStrobe is high.
        @(negedge Clk); bus0.RxData = 8'h08; bus0.RxValid = 1'b1;
        @(negedge Clk); bus0.RxData = 8'h02;
        @(negedge Clk); bus0.RxData = 8'h00;
        @(negedge Clk); bus0.RxData = 8'h08;
        checkOutput("b2b_strobe1", bus0.PacketStrobe, 1);
        checkOutput("b2b_posx1",   bus0.PosX, 543);
        @(negedge Clk); bus0.RxData = 8'h03;
        checkOutput("b2b_strobe_gap", bus0.PacketStrobe, 0);
        @(negedge Clk); bus0.RxData = 8'h00;
        @(negedge Clk); bus0.RxValid = 1'b0;
        checkOutput("b2b_strobe2", bus0.PacketStrobe, 1);
        checkOutput("b2b_posx2",   bus0.PosX, 546);
        checkOutput("b2b_sync",    bus0.SyncError, 0);

        // Dropping Enable mid-packet discards silently; bytes while disabled are ignored.
        applyStimulus(0, 8'h08, 1'b0);
        applyStimulus(0, 8'h05, 1'b0);
        @(negedge Clk); bus0.Enable = 1'b0;
        @(negedge Clk);
        checkOutput("enable_drop_sync", bus0.SyncError, 0);
        bus0.Enable = 1'b1;
        sendPacket3(8'h08, 8'h01, 8'h00);
        checkOutput("enable_pkt_posx", bus0.PosX, 547);
        bus0.Enable = 1'b0;
        sendPacket3(8'h08, 8'h05, 8'h05);
        checkOutput("disabled_strobe", bus0.PacketStrobe, 0);
        checkOutput("disabled_sync",   bus0.SyncError, 0);
        checkOutput("disabled_posx",   bus0.PosX, 547);
        bus0.Enable = 1'b1;

        // Reset mid-packet discards the partial packet.
        applyStimulus(0, 8'h08, 1'b0);
        applyStimulus(0, 8'h05, 1'b0);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midreset_posx", bus0.PosX, 319);
        checkOutput("midreset_posy", bus0.PosY, 239);
        Reset = 1'b0;
        sendPacket3(8'h08, 8'h01, 8'h00);
        checkOutput("midreset_pkt_strobe", bus0.PacketStrobe, 1);
        checkOutput("midreset_pkt_posx",   bus0.PosX, 320);
        checkOutput("midreset_pkt_posy",   bus0.PosY, 239);

        // Wheel accumulation and saturation in 4-byte mode.
        wExp = 0;
        for (int i = 0; i < 20; i++) begin
            sendPacket4(8'h08, 8'h00, 8'h00, 8'h01);
            wExp = (wExp + 1 > 7) ? 7 : wExp + 1;
            checkOutput($sformatf("wheel_up%0d_strobe", i), bus1.PacketStrobe, 1);
            checkOutput($sformatf("wheel_up%0d", i), bus1.Wheel, wExp);
        end
        sendPacket4(8'h08, 8'h00, 8'h00, 8'h0F);
        checkOutput("wheel_minus1", bus1.Wheel, 6);
        wExp = 6;
        for (int i = 0; i < 4; i++) begin
            sendPacket4(8'h08, 8'h00, 8'h00, 8'h08);
            wExp = (wExp - 8 < -8) ? -8 : wExp - 8;
            checkOutput($sformatf("wheel_down%0d", i), bus1.Wheel, wExp);
        end
        checkOutput("wheel_posx", bus1.PosX, 319);
        checkOutput("nowheel_stays0", bus0.Wheel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
